// File: rtl/nanorv32_rf_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter.
// Requester indices and the x0 write classification helpers.
package nanorv32_rf_wb_arbiter_pkg;

  localparam int WB_REQ_ALU  = 0;
  localparam int WB_REQ_LSU  = 1;
  localparam int WB_REQ_UROM = 2;
  localparam int WB_SEL_W    = 5;

  function automatic logic wb_null(input logic is_x0, input logic hid);
    return is_x0 & ~hid;
  endfunction

  function automatic logic wb_hid_x0(input logic is_x0, input logic hid);
    return is_x0 & hid;
  endfunction

endpackage

// File: rtl/nanorv32_rr_pick.sv
// Round-robin picker: one-hot first unmasked request at or
// after the start pointer, scanning upward modulo N.
module nanorv32_rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  input  logic [N-1:0]  mask_i,
  output logic [N-1:0]  gnt_o,
  output logic          found_o
);

  logic [N-1:0] elig;

  always_comb begin
    elig    = req_i & ~mask_i;
    gnt_o   = '0;
    found_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found_o && elig[i] &&
            ((i + N - int'(ptr_i)) % N) == k) begin
          gnt_o[i] = 1'b1;
          found_o  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/nanorv32_rf_wb_arbiter.sv
// Dual-port register-file write-back arbiter with round-robin
// grants, x0 filtering and same-register conflict suppression.
module nanorv32_rf_wb_arbiter
  import nanorv32_rf_wb_arbiter_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 wb_hold,
  input  logic [N_REQ-1:0]                     req_valid,
  input  logic [N_REQ*$clog2(NUM_REGS)-1:0]    req_sel,
  input  logic [N_REQ*DATA_W-1:0]              req_data,
  input  logic [N_REQ-1:0]                     req_hidden,
  output logic [N_REQ-1:0]                     req_ready,
  output logic [$clog2(NUM_REGS)-1:0]          sel_rd,
  output logic [DATA_W-1:0]                    rd,
  output logic                                 write_rd,
  output logic [$clog2(NUM_REGS)-1:0]          sel_rd2,
  output logic [DATA_W-1:0]                    rd2,
  output logic                                 write_rd2,
  output logic                                 wb_hidden_x0,
  output logic [$clog2(N_REQ)-1:0]             rr_ptr_o
);

  localparam int SW = $clog2(NUM_REGS);
  localparam int PW = $clog2(N_REQ);

  logic [N_REQ-1:0]  elig, no_mask, mask2, gnt1, gnt2;
  logic              found1, found2;
  logic [SW-1:0]     sel1, sel2;
  logic [DATA_W-1:0] dat1, dat2;
  logic              hid1, hid2;
  logic [PW-1:0]     last_idx;

  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]     sel_rd_q, sel_rd_d, sel_rd2_q, sel_rd2_d;
  logic [DATA_W-1:0] rd_q, rd_d, rd2_q, rd2_d;
  logic              write_rd_q, write_rd_d;
  logic              write_rd2_q, write_rd2_d;
  logic              hid_x0_q, hid_x0_d;

  assign elig    = wb_hold ? '0 : req_valid;
  assign no_mask = '0;

  nanorv32_rr_pick #(.N(N_REQ), .PW(PW)) u_pick1 (
    .req_i   (elig),
    .ptr_i   (rr_ptr_q),
    .mask_i  (no_mask),
    .gnt_o   (gnt1),
    .found_o (found1)
  );

  always_comb begin
    sel1 = '0;
    dat1 = '0;
    hid1 = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt1[i]) begin
        sel1 = req_sel[i*SW +: SW];
        dat1 = req_data[i*DATA_W +: DATA_W];
        hid1 = req_hidden[i];
      end
    end
  end

  // Port 2 may not reuse port 1's register, nor a second hidden x0.
  always_comb begin
    mask2 = gnt1;
    for (int i = 0; i < N_REQ; i++) begin
      if (found1 && req_sel[i*SW +: SW] == sel1)
        mask2[i] = 1'b1;
      if (found1 && wb_hid_x0(sel1 == '0, hid1) &&
          wb_hid_x0(req_sel[i*SW +: SW] == '0, req_hidden[i]))
        mask2[i] = 1'b1;
    end
  end

  nanorv32_rr_pick #(.N(N_REQ), .PW(PW)) u_pick2 (
    .req_i   (elig),
    .ptr_i   (rr_ptr_q),
    .mask_i  (mask2),
    .gnt_o   (gnt2),
    .found_o (found2)
  );

  always_comb begin
    sel2     = '0;
    dat2     = '0;
    hid2     = 1'b0;
    last_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt2[i]) begin
        sel2 = req_sel[i*SW +: SW];
        dat2 = req_data[i*DATA_W +: DATA_W];
        hid2 = req_hidden[i];
      end
      if (found2 ? gnt2[i] : gnt1[i])
        last_idx = PW'(i);
    end
  end

  assign req_ready = gnt1 | gnt2;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (found1)
      rr_ptr_d = (int'(last_idx) == N_REQ - 1) ? '0
               : PW'(last_idx + 1'b1);
    sel_rd_d    = sel1;
    rd_d        = dat1;
    write_rd_d  = found1 & ~wb_null(sel1 == '0, hid1);
    sel_rd2_d   = sel2;
    rd2_d       = dat2;
    write_rd2_d = found2 & ~wb_null(sel2 == '0, hid2);
    hid_x0_d    = (found1 & wb_hid_x0(sel1 == '0, hid1)) |
                  (found2 & wb_hid_x0(sel2 == '0, hid2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      sel_rd_q    <= '0;
      rd_q        <= '0;
      write_rd_q  <= 1'b0;
      sel_rd2_q   <= '0;
      rd2_q       <= '0;
      write_rd2_q <= 1'b0;
      hid_x0_q    <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      sel_rd_q    <= sel_rd_d;
      rd_q        <= rd_d;
      write_rd_q  <= write_rd_d;
      sel_rd2_q   <= sel_rd2_d;
      rd2_q       <= rd2_d;
      write_rd2_q <= write_rd2_d;
      hid_x0_q    <= hid_x0_d;
    end
  end

  assign rr_ptr_o     = rr_ptr_q;
  assign sel_rd       = sel_rd_q;
  assign rd           = rd_q;
  assign write_rd     = write_rd_q;
  assign sel_rd2      = sel_rd2_q;
  assign rd2          = rd2_q;
  assign write_rd2    = write_rd2_q;
  assign wb_hidden_x0 = hid_x0_q;

endmodule

// File: tb/tb_nanorv32_rf_wb_arbiter.sv
// Directed bench for the write-back arbiter with a small
// register-file model fed by the arbiter's strobes.
module tb_nanorv32_rf_wb_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_hold;
  logic [N-1:0]  req_valid;
  logic [N*5-1:0] req_sel;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_hidden;
  logic [N-1:0]  req_ready;
  logic [4:0]    sel_rd, sel_rd2;
  logic [DW-1:0] rd, rd2;
  logic          write_rd, write_rd2, wb_hidden_x0;
  logic [1:0]    rr_ptr_o;

  logic [DW-1:0] rf [32];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nanorv32_rf_wb_arbiter #(.N_REQ(N), .NUM_REGS(32), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_hold      (wb_hold),
    .req_valid    (req_valid),
    .req_sel      (req_sel),
    .req_data     (req_data),
    .req_hidden   (req_hidden),
    .req_ready    (req_ready),
    .sel_rd       (sel_rd),
    .rd           (rd),
    .write_rd     (write_rd),
    .sel_rd2      (sel_rd2),
    .rd2          (rd2),
    .write_rd2    (write_rd2),
    .wb_hidden_x0 (wb_hidden_x0),
    .rr_ptr_o     (rr_ptr_o)
  );

  initial for (int i = 0; i < 32; i++) rf[i] = '0;

  always @(posedge clk) begin
    if (write_rd)  rf[sel_rd]  <= rd;
    if (write_rd2) rf[sel_rd2] <= rd2;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] s,
                         input logic [DW-1:0] d, input logic h);
    req_valid[i]          = v;
    req_sel[i*5 +: 5]     = s;
    req_data[i*DW +: DW]  = d;
    req_hidden[i]         = h;
  endtask

  task automatic clr();
    req_valid  = '0;
    req_sel    = '0;
    req_data   = '0;
    req_hidden = '0;
  endtask

  logic [2:0] exp_rdy [6];
  logic [1:0] exp_ptr [6];
  logic [4:0] exp_sel [6];

  initial begin
    exp_rdy = '{3'b110, 3'b011, 3'b101, 3'b110, 3'b011, 3'b101};
    exp_ptr = '{2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1};
    exp_sel = '{5'd11, 5'd10, 5'd12, 5'd11, 5'd10, 5'd12};
    rst = 1'b1;
    wb_hold = 1'b0;
    clr();
    repeat (2) @(posedge clk);
    cyc();
    chk("rst_write_rd", write_rd, 0);
    chk("rst_write_rd2", write_rd2, 0);
    chk("rst_hidden", wb_hidden_x0, 0);
    chk("rst_ptr", rr_ptr_o, 0);
    chk("rst_sel_rd", sel_rd, 0);

    // reset on the accept edge
    set_req(0, 1, 5'd5, 32'hA5A5A5A5, 0);
    #1;
    chk("rstx_ready", req_ready, 3'b001);
    cyc();
    chk("rstx_write_rd", write_rd, 0);
    chk("rstx_ptr", rr_ptr_o, 0);
    clr();
    rst = 1'b0;
    cyc();
    cyc();
    chk("rstx_rf5", rf[5], 0);

    // two requesters, both ports
    set_req(0, 1, 5'd3, 32'h11, 0);
    set_req(1, 1, 5'd4, 32'h22, 0);
    #1;
    chk("two_ready", req_ready, 3'b011);
    cyc();
    clr();
    chk("two_write_rd", write_rd, 1);
    chk("two_sel_rd", sel_rd, 3);
    chk("two_rd", rd, 32'h11);
    chk("two_write_rd2", write_rd2, 1);
    chk("two_sel_rd2", sel_rd2, 4);
    chk("two_rd2", rd2, 32'h22);
    chk("two_ptr", rr_ptr_o, 2);

    // hidden x0 from micro-ROM
    set_req(2, 1, 5'd0, 32'h55, 1);
    #1;
    chk("hx0_ready", req_ready, 3'b100);
    cyc();
    clr();
    chk("hx0_write_rd", write_rd, 1);
    chk("hx0_sel_rd", sel_rd, 0);
    chk("hx0_rd", rd, 32'h55);
    chk("hx0_flag", wb_hidden_x0, 1);
    chk("hx0_write_rd2", write_rd2, 0);
    chk("hx0_ptr", rr_ptr_o, 0);
    cyc();
    chk("idle_write_rd", write_rd, 0);
    chk("idle_flag", wb_hidden_x0, 0);

    // same-register conflict
    set_req(0, 1, 5'd7, 32'h70, 0);
    set_req(1, 1, 5'd7, 32'h77, 0);
    #1;
    chk("conf_ready", req_ready, 3'b001);
    cyc();
    set_req(0, 0, 5'd0, 32'h0, 0);
    chk("conf_write_rd", write_rd, 1);
    chk("conf_rd", rd, 32'h70);
    chk("conf_write_rd2", write_rd2, 0);
    chk("conf_ptr", rr_ptr_o, 1);
    #1;
    chk("conf_ready2", req_ready, 3'b010);
    cyc();
    clr();
    chk("conf2_rd", rd, 32'h77);
    chk("conf2_sel", sel_rd, 7);
    chk("conf2_ptr", rr_ptr_o, 2);
    cyc();
    chk("conf_rf7", rf[7], 32'h77);

    // null write to x0
    set_req(0, 1, 5'd0, 32'h99, 0);
    #1;
    chk("null_ready", req_ready, 3'b001);
    cyc();
    clr();
    chk("null_write_rd", write_rd, 0);
    chk("null_write_rd2", write_rd2, 0);
    chk("null_flag", wb_hidden_x0, 0);
    chk("null_ptr", rr_ptr_o, 1);

    // three continuously valid requesters
    set_req(0, 1, 5'd10, 32'hA0, 0);
    set_req(1, 1, 5'd11, 32'hB1, 0);
    set_req(2, 1, 5'd12, 32'hC2, 0);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_ready", req_ready, exp_rdy[k]);
      cyc();
      chk("rr_ptr", rr_ptr_o, exp_ptr[k]);
      chk("rr_sel_rd", sel_rd, exp_sel[k]);
      chk("rr_both", {write_rd, write_rd2}, 2'b11);
    end

    // hold with everything valid
    wb_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_ready", req_ready, 3'b000);
      cyc();
      chk("hold_strobes", {write_rd, write_rd2}, 2'b00);
      chk("hold_ptr", rr_ptr_o, 1);
    end
    wb_hold = 1'b0;
    #1;
    chk("rel_ready", req_ready, 3'b110);
    cyc();
    clr();
    chk("rel_sel_rd", sel_rd, 11);
    chk("rel_sel_rd2", sel_rd2, 12);
    chk("rel_ptr", rr_ptr_o, 0);

    // two hidden x0 writes in one cycle
    set_req(0, 1, 5'd0, 32'h1, 1);
    set_req(1, 1, 5'd0, 32'h2, 1);
    #1;
    chk("dhx0_ready", req_ready, 3'b001);
    cyc();
    clr();
    chk("dhx0_flag", wb_hidden_x0, 1);
    chk("dhx0_write_rd", write_rd, 1);
    chk("dhx0_write_rd2", write_rd2, 0);
    chk("dhx0_ptr", rr_ptr_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
